instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 116 +++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: program memory, fetch FSM and an IR with a valid/ready handshake.
// Optional build macro IFETCH_STEP_EDGE_EN: step becomes a synchronised, edge-detected active-low button.
module instr_fetch #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter logic [3:0]  HALT_OP   = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_en,
  input  logic [7:0]  load_addr,
  input  logic [15:0] load_data,
  input  logic        run,
  input  logic        step,
  input  logic        restart,
  input  logic        branch_en,
  input  logic [7:0]  branch_target,
  input  logic        ir_ready,
  output logic        ir_valid,
  output logic [15:0] ir_data,
  output logic [3:0]  opcode,
  output logic [3:0]  f_c,
  output logic [3:0]  f_a,
  output logic [3:0]  f_b,
  output logic [7:0]  pc,
  output logic        halted
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_HALT
  } state_t;

  state_t      r_state;
  logic [15:0] r_mem [MEM_DEPTH];
  logic        w_step_req;
  logic        w_load_ok;

`ifdef IFETCH_STEP_EDGE_EN
  // [0],[1] synchronise the button; [2] delays once more so a high->low transition is one pulse.
  logic [2:0] r_step_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_step_sync <= 3'b111;
    else        r_step_sync <= {r_step_sync[1:0], step};
  end

  assign w_step_req = r_step_sync[2] & ~r_step_sync[1];
`else
  assign w_step_req = step;
`endif

  // Program writes are only accepted while the fetch path is quiescent; restart wins over a load.
  assign w_load_ok = load_en && !restart && ((r_state == S_IDLE) || (r_state == S_HALT));

  // NOTE: the memory array is deliberately left out of reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (w_load_ok) r_mem[load_addr[AW-1:0]] <= load_data;
  end

  // NOTE: every state register here uses <= so all of them see pre-edge values of each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      pc       <= 8'h00;
      ir_data  <= 16'h0000;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else if (restart) begin
      r_state  <= S_IDLE;
      pc       <= 8'h00;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run || w_step_req) r_state <= S_FETCH;
        end
        S_FETCH: begin
          ir_data  <= r_mem[pc[AW-1:0]];
          ir_valid <= 1'b1;
          r_state  <= S_HOLD;
        end
        S_HOLD: begin
          if (ir_ready) begin
            ir_valid <= 1'b0;
            pc       <= branch_en ? branch_target : pc + 8'd1;
            if (ir_data[15:12] == HALT_OP) begin
              r_state <= S_HALT;
              halted  <= 1'b1;
            end else if (run) begin
              r_state <= S_FETCH;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign opcode = ir_data[15:12];
  assign f_c    = ir_data[11:8];
  assign f_a    = ir_data[7:4];
  assign f_b    = ir_data[3:0];

endmodule
